// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - PI/DMA arbiter sharing one SDRAM controller request port
module sdram_arbiter #(
    parameter int unsigned PI_STREAK_MAX = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        pi_request_i,
    input  logic        pi_write_i,
    input  logic [31:0] pi_address_i,
    input  logic [15:0] pi_wdata_i,
    output logic        pi_ack_o,
    output logic [15:0] pi_rdata_o,
    input  logic        dma_request_i,
    input  logic        dma_write_i,
    input  logic [31:0] dma_address_i,
    input  logic [15:0] dma_wdata_i,
    output logic        dma_ack_o,
    output logic [15:0] dma_rdata_o,
    output logic        mem_request_o,
    output logic        mem_write_o,
    output logic [31:0] mem_address_o,
    output logic [15:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [15:0] mem_rdata_i,
    output logic        owner_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_PI  = 2'd1,
        GRANT_DMA = 2'd2
    } state_e;

    localparam logic [3:0] STREAK_MAX = 4'(PI_STREAK_MAX);

    state_e      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic        mem_request_q, mem_request_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        pick_pi;
    logic        pick_dma;

    // Arbitration: PI wins unless DMA is waiting and PI has used up its streak.
    always_comb begin
        pick_pi  = pi_request_i & (~dma_request_i | (streak_q < STREAK_MAX));
        pick_dma = dma_request_i & ~pick_pi;
    end

    // Next-state logic: latch the winner's command on grant, release on mem_ack.
    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        mem_request_d = mem_request_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (pick_pi) begin
                    state_d       = GRANT_PI;
                    mem_request_d = 1'b1;
                    mem_write_d   = pi_write_i;
                    mem_address_d = pi_address_i & ~32'h1;
                    mem_wdata_d   = pi_wdata_i;
                    // pick_pi with DMA waiting implies streak < max, so +1 cannot overshoot
                    streak_d      = dma_request_i ? streak_q + 4'd1 : 4'd0;
                end else if (pick_dma) begin
                    state_d       = GRANT_DMA;
                    mem_request_d = 1'b1;
                    mem_write_d   = dma_write_i;
                    mem_address_d = dma_address_i & ~32'h1;
                    mem_wdata_d   = dma_wdata_i;
                    streak_d      = 4'd0;
                end
            end
            GRANT_PI, GRANT_DMA: begin
                if (mem_ack_i) begin
                    state_d       = IDLE;
                    mem_request_d = 1'b0;
                end
            end
            default: begin
                state_d       = IDLE;
                mem_request_d = 1'b0;
            end
        endcase
    end

    // State and command registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            streak_q      <= 4'd0;
            mem_request_q <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= 32'd0;
            mem_wdata_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            streak_q      <= streak_d;
            mem_request_q <= mem_request_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    // Zero-latency ack routing; a reset cycle abandons the grant so no ack leaks out.
    always_comb begin
        pi_ack_o      = mem_ack_i & (state_q == GRANT_PI) & ~reset_i;
        dma_ack_o     = mem_ack_i & (state_q == GRANT_DMA) & ~reset_i;
        pi_rdata_o    = mem_rdata_i;
        dma_rdata_o   = mem_rdata_i;
        mem_request_o = mem_request_q;
        mem_write_o   = mem_write_q;
        mem_address_o = mem_address_q;
        mem_wdata_o   = mem_wdata_q;
        owner_o       = (state_q == GRANT_DMA);
        busy_o        = (state_q != IDLE);
    end

endmodule
